// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix keypad column scanner with whole-scan debounce and a
//            valid/ack handshake for one accepted key code.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
   parameter int SCAN_DIV = 50000,
   parameter int DB_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack
);

   localparam int                 c_DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]         c_DB_MAX   = 4'(DB_SCANS);
   localparam logic [1:0]         c_RES_NONE  = 2'd0;
   localparam logic [1:0]         c_RES_KEY   = 2'd1;
   localparam logic [1:0]         c_RES_MULTI = 2'd2;

   typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, HELD = 2'd2} state_t;

   function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'h1;  4'b00_01: code = 4'h2;  4'b00_10: code = 4'h3;  4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;  4'b01_01: code = 4'h5;  4'b01_10: code = 4'h6;  4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;  4'b10_01: code = 4'h8;  4'b10_10: code = 4'h9;  4'b10_11: code = 4'hC;
         4'b11_00: code = 4'h0;  4'b11_01: code = 4'hF;  4'b11_10: code = 4'hE;  default:  code = 4'hD;
      endcase
      return code;
   endfunction

   logic [3:0]         r_sync1, r_sync2;
   logic [c_DIV_W-1:0] r_div;
   logic [1:0]         r_col;
   logic               r_acc_seen, r_acc_multi;
   logic [3:0]         r_acc_code;
   logic [1:0]         r_prev_class;
   logic [3:0]         r_prev_code;
   logic [3:0]         r_match;
   logic               r_key_stable, r_none_stable;
   logic [3:0]         r_stable_code;
   state_t             r_state;

   logic       w_sample, w_scan_end, w_one, w_seen, w_multi, w_same;
   logic [3:0] w_low, w_code, w_res_code, w_match_next;
   logic [1:0] w_row, w_col_next, w_res_class;

   // Fold the current column's sample into the running scan result.
   always_comb begin
      w_sample   = (r_div == c_DIV_LAST);
      w_scan_end = w_sample && (r_col == 2'd3);
      w_col_next = r_col + 2'd1;
      w_low      = ~r_sync2;
      w_one      = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
      w_row      = w_low[0] ? 2'd0 : w_low[1] ? 2'd1 : w_low[2] ? 2'd2 : 2'd3;
      w_seen     = r_acc_seen;
      w_multi    = r_acc_multi;
      w_code     = r_acc_code;
      if (w_low != 4'd0) begin
         if (!w_one || r_acc_seen) begin
            w_multi = 1'b1;
         end else begin
            w_seen = 1'b1;
            w_code = keymap(w_row, r_col);
         end
      end
      if (w_multi) begin
         w_res_class = c_RES_MULTI;
         w_res_code  = 4'h0;
      end else if (w_seen) begin
         w_res_class = c_RES_KEY;
         w_res_code  = w_code;
      end else begin
         w_res_class = c_RES_NONE;
         w_res_code  = 4'h0;
      end
      w_same       = (w_res_class == r_prev_class) && (w_res_code == r_prev_code);
      w_match_next = !w_same ? 4'd1 : (r_match == c_DB_MAX) ? r_match : r_match + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1       <= 4'b1111;
         r_sync2       <= 4'b1111;
         r_div         <= '0;
         r_col         <= 2'd0;
         cols          <= 4'b1110;
         r_acc_seen    <= 1'b0;
         r_acc_multi   <= 1'b0;
         r_acc_code    <= 4'h0;
         r_prev_class  <= c_RES_NONE;
         r_prev_code   <= 4'h0;
         r_match       <= 4'd0;
         r_key_stable  <= 1'b0;
         r_none_stable <= 1'b0;
         r_stable_code <= 4'h0;
         key_code      <= 4'h0;
         key_valid     <= 1'b0;
         r_state       <= IDLE;
      end else begin
         r_sync1       <= rows;
         r_sync2       <= r_sync1;
         r_key_stable  <= 1'b0;
         r_none_stable <= 1'b0;
         if (w_sample) begin
            r_div <= '0;
            r_col <= w_col_next;
            cols  <= ~(4'b0001 << w_col_next);
            if (w_scan_end) begin
               r_acc_seen    <= 1'b0;
               r_acc_multi   <= 1'b0;
               r_acc_code    <= 4'h0;
               r_prev_class  <= w_res_class;
               r_prev_code   <= w_res_code;
               r_match       <= w_match_next;
               r_stable_code <= w_res_code;
               // A key qualifies only on the scan where the count first saturates.
               r_key_stable  <= (w_res_class == c_RES_KEY) && (w_match_next == c_DB_MAX)
                                && (r_match != c_DB_MAX);
               r_none_stable <= (w_res_class == c_RES_NONE) && (w_match_next == c_DB_MAX);
            end else begin
               r_acc_seen  <= w_seen;
               r_acc_multi <= w_multi;
               r_acc_code  <= w_code;
            end
         end else begin
            r_div <= r_div + c_DIV_W'(1);
         end

         case (r_state)
            IDLE: begin
               if (r_key_stable) begin
                  key_code  <= r_stable_code;
                  key_valid <= 1'b1;
                  r_state   <= PRESENT;
               end
            end
            PRESENT: begin
               if (key_ack) begin
                  key_valid <= 1'b0;
                  r_state   <= HELD;
               end
            end
            HELD: begin
               if (r_none_stable) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
